spi_slave: RTL and testbench

- SPI mode-0 slave front end that sits directly upstream of the single-port RAM and converts serial master traffic into 10-bit RAM command words.
- Upper two bits of each word are the RAM opcode: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
- Receives the read byte back from the RAM (tx_data/tx_valid) and shifts it out on MISO within the same chip-select frame.
- Oversamples the SPI pins on the system clock clk.

---
 rtl/spi_ram_pkg.sv | 10 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave.sv | 117 +++++++++++
 tb/tb_spi_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared state encoding, RAM opcodes and widths for the SPI-to-RAM path
package spi_ram_pkg;
    localparam int WORD_W = 10;
    localparam int DATA_W = 8;
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronises the SPI pins into clk and flags sclk edges
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_i,
    input  logic ss_n_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_n_s_o,
    output logic mosi_s_o
);
    logic [SYNC_STAGES-1:0] sclk_q, ss_n_q, mosi_q;
    logic sclk_prev_q;

    // synchroniser chains; ss_n resets to the deselected level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            ss_n_q      <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            ss_n_q      <= {ss_n_q[SYNC_STAGES-2:0], ss_n_i};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    assign ss_n_s_o    = ss_n_q[SYNC_STAGES-1];
    assign mosi_s_o    = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave turning master frames into RAM command words and returning read bytes
module spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_W      = spi_ram_pkg::WORD_W,
    parameter int DATA_W      = spi_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);
    import spi_ram_pkg::*;

    localparam int CW = $clog2(WORD_W + 1);
    localparam int TW = $clog2(DATA_W + 2);

    state_t state_q, state_d;
    logic sclk_rise, sclk_fall, ss_n_s, mosi_s;
    logic [CW-1:0] cnt_q;
    logic [WORD_W-2:0] sh_q;
    logic [WORD_W-1:0] rx_data_q;
    logic rx_valid_q, rd_seen_q, tx_ld_q, miso_q, tx_phase;
    logic [DATA_W-1:0] tx_sh_q;
    logic [TW-1:0] txn_q;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk_i     (sclk),
        .ss_n_i     (ss_n),
        .mosi_i     (mosi),
        .sclk_rise_o(sclk_rise),
        .sclk_fall_o(sclk_fall),
        .ss_n_s_o   (ss_n_s),
        .mosi_s_o   (mosi_s)
    );

    // the byte goes out only once the read-data word itself is complete
    assign tx_phase = (state_q == READ_DATA) && (cnt_q == CW'(WORD_W));

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state: the command's top bit picks the path, deselect always returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!ss_n_s) state_d = CHK_CMD;
            CHK_CMD: if (sclk_rise) state_d = (mosi_s != OP_RD_ADDR[1]) ? WRITE : rd_seen_q ? READ_DATA : READ_ADD;
            default: ;
        endcase
        if (state_q != IDLE && ss_n_s) state_d = IDLE;
    end

    // receive shifter, word strobe, read-address tracking and transmit shifter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            tx_sh_q    <= '0;
            tx_ld_q    <= 1'b0;
            txn_q      <= '0;
            miso_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (state_q == IDLE || state_d == IDLE) begin
                cnt_q   <= '0;
                txn_q   <= '0;
                tx_ld_q <= 1'b0;
                tx_sh_q <= '0;
                miso_q  <= 1'b0;
                if (tx_phase) rd_seen_q <= 1'b0;
            end else begin
                if (sclk_rise && cnt_q < CW'(WORD_W)) begin
                    sh_q  <= {sh_q[WORD_W-3:0], mosi_s};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WORD_W - 1)) begin
                        rx_data_q  <= {sh_q, mosi_s};
                        rx_valid_q <= 1'b1;
                        if (state_q == READ_ADD) rd_seen_q <= 1'b1;
                    end
                end
                if (tx_phase) begin
                    if (!rx_valid_q && !tx_ld_q && txn_q == '0 && tx_valid) begin
                        tx_sh_q <= tx_data;
                        tx_ld_q <= 1'b1;
                    end
                    if (sclk_fall && txn_q < TW'(DATA_W)) begin
                        miso_q  <= tx_sh_q[DATA_W-1];
                        tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
                        txn_q   <= txn_q + 1'b1;
                    end else if (sclk_fall && txn_q == TW'(DATA_W)) begin
                        miso_q    <= 1'b0;
                        rd_seen_q <= 1'b0;
                        txn_q     <= txn_q + 1'b1;
                    end
                end
            end
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: frame-level checks of spi_slave against a transaction model
module tb_spi_slave;
    import spi_ram_pkg::*;

    localparam int H = 8;

    logic clk, rst_n, sclk, ss_n, mosi, miso, rx_valid, tx_valid;
    logic [9:0] rx_data;
    logic [7:0] tx_data;

    int n_cmp = 0;
    int n_fail = 0;
    int dbl = 0;
    bit resp_en = 0;
    logic [7:0] resp_byte = '0;
    logic [9:0] rxq[$];
    bit m_seen = 0;
    logic [9:0] m_last = '0;

    typedef struct {
        logic [9:0] w;
        int nb;
        bit resp;
        logic [7:0] txb;
        int exp_np;
        logic [9:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    spi_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .ss_n    (ss_n),
        .mosi    (mosi),
        .miso    (miso),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // rx_valid monitor: record every word and flag back-to-back strobes
    initial begin
        logic prev = 0;
        forever begin
            @(negedge clk);
            if (rx_valid) rxq.push_back(rx_data);
            if (rx_valid && prev) dbl++;
            prev = rx_valid;
        end
    end

    // RAM stand-in: answer one clk after a word strobe when this frame expects data back
    initial begin
        tx_valid = 0;
        tx_data = '0;
        forever begin
            @(negedge clk);
            if (rx_valid && resp_en) begin
                @(negedge clk);
                tx_data = resp_byte;
                tx_valid = 1;
                @(negedge clk);
                tx_valid = 0;
                tx_data = 8'($urandom);
            end
        end
    end

    // transaction model: what the master should see for one frame
    task automatic model(input logic [9:0] w, input int nb, input bit resp, input logic [7:0] txb,
                         output int np, output logic [7:0] mb);
        np = 0;
        mb = 8'h00;
        if (nb >= 10) begin
            np = 1;
            m_last = w;
            if (w[9]) begin
                if (!m_seen) m_seen = 1;
                else begin
                    m_seen = 0;
                    mb = resp ? (txb & 8'(8'hFF << (18 - (nb > 18 ? 18 : nb)))) : 8'h00;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [9:0] w, input int nb, input bit resp, input logic [7:0] txb,
                              output int np, output logic [9:0] last, output logic [7:0] mb);
        int base;
        base = rxq.size();
        resp_en = resp;
        resp_byte = txb;
        mb = 8'h00;
        @(negedge clk);
        ss_n = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            mosi = (i < 10) ? w[9-i] : 1'($urandom);
            repeat (H) @(negedge clk);
            if (i >= 10 && i < 18) mb[17-i] = miso;
            sclk = 1;
            repeat (H) @(negedge clk);
            sclk = 0;
        end
        repeat (H) @(negedge clk);
        ss_n = 1;
        repeat (3 * H) @(negedge clk);
        np = rxq.size() - base;
        last = (np > 0) ? rxq[$] : 10'h000;
        resp_en = 0;
    endtask

    task automatic run_checked(input string tag, input logic [9:0] w, input int nb, input bit resp,
                               input logic [7:0] txb, input int exp_np, input logic [9:0] exp_rx,
                               input logic [7:0] exp_miso);
        int np;
        logic [9:0] last;
        logic [7:0] mb;
        send_frame(w, nb, resp, txb, np, last, mb);
        chk({tag, " pulses"}, np, exp_np);
        if (exp_np > 0) chk({tag, " rx_data"}, last, exp_rx);
        chk({tag, " miso_byte"}, mb, exp_miso);
        chk({tag, " rx_hold"}, rx_data, m_last);
        chk({tag, " miso_idle"}, miso, 0);
    endtask

    initial begin
        vec_t tbl[20];
        int np;
        logic [7:0] mb;
        rst_n = 0;
        sclk = 0;
        ss_n = 1;
        mosi = 0;
        tbl[0]  = '{{OP_WR_ADDR, 8'h5A}, 10, 0, 8'h00, 1, 10'h05A, 8'h00};
        tbl[1]  = '{{OP_WR_DATA, 8'hC3}, 18, 0, 8'h00, 1, 10'h1C3, 8'h00};
        tbl[2]  = '{{OP_RD_ADDR, 8'h07}, 18, 1, 8'hFF, 1, 10'h207, 8'h00};
        tbl[3]  = '{{OP_RD_DATA, 8'h00}, 18, 1, 8'hA5, 1, 10'h300, 8'hA5};
        tbl[4]  = '{{OP_WR_ADDR, 8'hFF}, 6, 0, 8'h00, 0, 10'h000, 8'h00};
        tbl[5]  = '{{OP_WR_ADDR, 8'hF0}, 10, 0, 8'h00, 1, 10'h0F0, 8'h00};
        tbl[6]  = '{{OP_RD_ADDR, 8'hAA}, 10, 0, 8'h00, 1, 10'h2AA, 8'h00};
        tbl[7]  = '{{OP_RD_ADDR, 8'h55}, 18, 1, 8'h3C, 1, 10'h255, 8'h3C};
        tbl[8]  = '{{OP_RD_DATA, 8'h00}, 18, 0, 8'h00, 1, 10'h300, 8'h00};
        tbl[9]  = '{{OP_RD_DATA, 8'hFF}, 18, 0, 8'h00, 1, 10'h3FF, 8'h00};
        tbl[10] = '{{OP_RD_ADDR, 8'h01}, 18, 1, 8'h81, 1, 10'h201, 8'h00};
        tbl[11] = '{{OP_RD_DATA, 8'h80}, 10, 0, 8'h00, 1, 10'h380, 8'h00};
        tbl[12] = '{{OP_RD_DATA, 8'hC3}, 18, 1, 8'h99, 1, 10'h3C3, 8'h00};
        tbl[13] = '{{OP_RD_DATA, 8'h11}, 14, 1, 8'hB7, 1, 10'h311, 8'hB0};
        tbl[14] = '{{OP_RD_ADDR, 8'h00}, 10, 0, 8'h00, 1, 10'h200, 8'h00};
        tbl[15] = '{{OP_RD_DATA, 8'hE7}, 18, 1, 8'h5A, 1, 10'h3E7, 8'h5A};
        tbl[16] = '{{OP_RD_ADDR, 8'hFF}, 9, 0, 8'h00, 0, 10'h000, 8'h00};
        tbl[17] = '{{OP_RD_ADDR, 8'hFF}, 18, 1, 8'h11, 1, 10'h2FF, 8'h00};
        tbl[18] = '{{OP_RD_DATA, 8'h01}, 4, 0, 8'h00, 0, 10'h000, 8'h00};
        tbl[19] = '{{OP_RD_DATA, 8'h01}, 18, 1, 8'hC3, 1, 10'h301, 8'hC3};

        // reset with the pins thrashing
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            sclk = 1'($urandom);
            ss_n = 1'($urandom);
            mosi = 1'($urandom);
            tx_valid = 1'($urandom);
            tx_data = 8'($urandom);
            chk("reset outputs", {miso, rx_valid, rx_data}, 12'h000);
        end
        sclk = 0;
        ss_n = 1;
        mosi = 0;
        tx_valid = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (3 * H) @(negedge clk);
        chk("post-reset outputs", {miso, rx_valid, rx_data}, 12'h000);

        // directed frames
        for (int i = 0; i < 20; i++) begin
            model(tbl[i].w, tbl[i].nb, tbl[i].resp, tbl[i].txb, np, mb);
            run_checked($sformatf("vec%0d", i), tbl[i].w, tbl[i].nb, tbl[i].resp, tbl[i].txb,
                        tbl[i].exp_np, tbl[i].exp_rx, tbl[i].exp_miso);
        end

        // mid-frame reset after a read-address frame clears the pending read
        model(10'h2AA, 10, 0, 8'h00, np, mb);
        run_checked("pre-reset rd_addr", 10'h2AA, 10, 0, 8'h00, 1, 10'h2AA, 8'h00);
        @(negedge clk);
        ss_n = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mosi = 1'($urandom);
            repeat (H) @(negedge clk);
            sclk = 1;
            repeat (H) @(negedge clk);
            sclk = 0;
        end
        rst_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midframe reset outputs", {miso, rx_valid, rx_data}, 12'h000);
        end
        rst_n = 1;
        m_seen = 0;
        m_last = '0;
        repeat (2 * H) @(negedge clk);
        chk("ss_n held low across reset", {rx_valid, rx_data}, 11'h000);
        ss_n = 1;
        repeat (3 * H) @(negedge clk);
        model(10'h3A5, 18, 1, 8'h77, np, mb);
        run_checked("after reset rd", 10'h3A5, 18, 1, 8'h77, 1, 10'h3A5, 8'h00);

        // random frames against the model
        for (int i = 0; i < 40; i++) begin
            logic [9:0] w;
            logic [7:0] txb;
            int nb;
            bit resp;
            int sel;
            w = 10'($urandom);
            txb = 8'($urandom);
            resp = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 3);
            nb = (sel == 0) ? $urandom_range(1, 9) : (sel == 1) ? 10 : (sel == 2) ? 18 : $urandom_range(11, 17);
            model(w, nb, resp, txb, np, mb);
            run_checked($sformatf("rnd%0d w=%h nb=%0d", i, w, nb), w, nb, resp, txb, np, w, mb);
        end

        chk("rx_valid back-to-back", dbl, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
